// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift engine: shift modes and FSM states.
package shift_pkg;

  // Shift mode encodings; 2'b11 is reserved and behaves as logical.
  localparam logic [1:0] SHM_LOGIC = 2'b00;
  localparam logic [1:0] SHM_ARITH = 2'b01;
  localparam logic [1:0] SHM_ROT   = 2'b10;

  // Engine FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// Combinational single-bit shift step: one position left or right in the selected mode.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  logic             left_direction,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q
);

  logic is_rot;
  logic is_arith;

  assign is_rot   = (mode == SHM_ROT);
  assign is_arith = (mode == SHM_ARITH);

  // Pick the bit that enters the vacated position, then shift by one.
  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    q = d;
    if (left_direction) begin
      // Arithmetic left is identical to logical left.
      q = {d[WIDTH-2:0], (is_rot ? d[WIDTH-1] : 1'b0)};
    end else begin
      if (is_rot)        q = {d[0], d[WIDTH-1:1]};
      else if (is_arith) q = {d[WIDTH-1], d[WIDTH-1:1]};
      else               q = {1'b0, d[WIDTH-1:1]};
    end
  end

endmodule : shift_step

// File: rtl/seq_shift_engine.sv
// Multi-cycle shift engine: accepts a request, shifts one bit per clock, holds the result until taken.
module seq_shift_engine
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             left_direction,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] step_q;
  logic [AMT_W-1:0] cnt_q;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic             accept;

  // A request is only taken in IDLE, so a DONE-state handshake can never overlap an acceptance.
  assign accept = in_valid && (state_q == ST_IDLE);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .d              (data_q),
    .left_direction (dir_q),
    .mode           (mode_q),
    .q              (step_q)
  );

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: zero-amount requests skip SHIFT; the last step is the one taken with cnt_q == 1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (in_amt != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (cnt_q == AMT_W'(1)) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state; result is driven only while presented.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    out_data  = (state_q == ST_DONE) ? data_q : '0;
  end

  // Datapath: capture the request on acceptance, then apply one step per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      mode_q <= SHM_LOGIC;
    end else if (accept) begin
      data_q <= in_data;
      cnt_q  <= in_amt;
      dir_q  <= left_direction;
      mode_q <= in_mode;
    end else if (state_q == ST_SHIFT) begin
      data_q <= step_q;
      cnt_q  <= cnt_q - AMT_W'(1);
    end
  end

endmodule : seq_shift_engine

// File: tb/tb_seq_shift_engine.sv
// Directed and randomised checks of seq_shift_engine results, latency, handshakes and reset.
module tb_seq_shift_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       left_direction;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_shift_engine #(.WIDTH(8), .AMT_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_amt         (in_amt),
    .left_direction (left_direction),
    .in_mode        (in_mode),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .busy           (busy)
  );

  // Barrel-shifter reference: whole-amount shifts on a doubled word.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] a,
                                           input logic l, input logic [1:0] m);
    logic [15:0] dd;
    dd = {d, d};
    if (m == 2'b10) begin
      if (l) begin dd = dd << a; return dd[15:8]; end
      else   begin dd = dd >> a; return dd[7:0];  end
    end
    if (l)         return d << a;
    if (m == 2'b01) return $unsigned($signed(d) >>> a);
    return d >> a;
  endfunction

  // Issue one request at a negedge in IDLE, then scramble inputs and wait for out_valid.
  // lat is the number of cycles after acceptance until out_valid (-1 on timeout).
  task automatic run_req(input logic [7:0] d, input logic [2:0] a, input logic l,
                         input logic [1:0] m, output logic [7:0] res, output int lat);
    int k;
    lat = -1;
    res = 8'hxx;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) return;
    in_valid = 1'b1; in_data = d; in_amt = a; left_direction = l; in_mode = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_data = ~d; in_amt = ~a; left_direction = ~l; in_mode = ~m;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        res = out_data;
        break;
      end
    end
  endtask

  // Complete the output handshake from a negedge in DONE.
  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Run one request and compare result and latency against expectations.
  task automatic expect_req(input string name, input logic [7:0] d, input logic [2:0] a,
                            input logic l, input logic [1:0] m, input logic [7:0] exp_data);
    logic [7:0] res;
    int         lat;
    run_req(d, a, l, m, res, lat);
    checks++;
    if (res !== exp_data) begin
      errors++;
      $display("FAIL %s data: got %h expected %h", name, res, exp_data);
    end
    checks++;
    if (lat != int'(a) + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, int'(a) + 1);
    end
    take();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, out_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset state: got rdy=%b vld=%b busy=%b data=%h expected 1 0 0 00",
               in_ready, out_valid, busy, out_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_left_logical();
    expect_req("left_logical_B1_3", 8'hB1, 3'd3, 1'b1, 2'b00, 8'h88);
  endtask

  task automatic test_right_arith();
    expect_req("right_arith_B1_2", 8'hB1, 3'd2, 1'b0, 2'b01, 8'hEC);
    expect_req("right_arith_31_2", 8'h31, 3'd2, 1'b0, 2'b01, 8'h0C);
  endtask

  task automatic test_rotate();
    expect_req("rot_right_B1_3", 8'hB1, 3'd3, 1'b0, 2'b10, 8'h36);
    expect_req("rot_left_81_7",  8'h81, 3'd7, 1'b1, 2'b10, 8'hC0);
  endtask

  task automatic test_mode_reserved();
    expect_req("mode11_right_B1_3", 8'hB1, 3'd3, 1'b0, 2'b11, 8'h16);
    expect_req("mode11_left_B1_1",  8'hB1, 3'd1, 1'b1, 2'b11, 8'h62);
  endtask

  task automatic test_amt_zero();
    logic [7:0] res;
    int         lat;
    run_req(8'h5A, 3'd0, 1'b1, 2'b00, res, lat);
    checks++;
    if (res !== 8'h5A || lat != 1) begin
      errors++;
      $display("FAIL amt_zero: got data %h lat %0d expected 5a lat 1", res, lat);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL amt_zero busy: got rdy=%b busy=%b expected 0 1", in_ready, busy);
    end
    take();
  endtask

  task automatic test_backpressure();
    logic [7:0] res;
    int         lat;
    run_req(8'hB1, 3'd3, 1'b1, 2'b00, res, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h88 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure hold %0d: got vld=%b data=%h rdy=%b expected 1 88 0",
                 i, out_valid, out_data, in_ready);
      end
    end
    // Offer a new request during the handshake cycle; it must not be taken.
    in_valid = 1'b1; in_data = 8'h0F; in_amt = 3'd1; left_direction = 1'b1; in_mode = 2'b00;
    take();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure release: got rdy=%b vld=%b busy=%b expected 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd7; left_direction = 1'b1; in_mode = 2'b00;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, out_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_shift: got rdy=%b vld=%b busy=%b data=%h expected 1 0 0 00",
               in_ready, out_valid, busy, out_data);
    end
    rst_n = 1'b1;
    expect_req("after_reset_01_left1", 8'h01, 3'd1, 1'b1, 2'b00, 8'h02);
  endtask

  task automatic test_random();
    logic [7:0] d, res, exp_data;
    logic [2:0] a;
    logic       l;
    logic [1:0] m;
    int         lat;
    int         bad;
    bad = 0;
    for (int n = 0; n < 200; n++) begin
      d = 8'($urandom); a = 3'($urandom); l = 1'($urandom); m = 2'($urandom);
      exp_data = ref_shift(d, a, l, m);
      run_req(d, a, l, m, res, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (res !== exp_data || lat != int'(a) + 1 || out_data !== exp_data) begin
        errors++;
        if (bad < 10)
          $display("FAIL random %0d d=%h a=%0d l=%b m=%b: got %h lat %0d expected %h lat %0d",
                   n, d, a, l, m, res, lat, exp_data, int'(a) + 1);
        bad++;
      end
      take();
    end
  endtask

  initial begin
    in_valid = 1'b0; in_data = 8'h00; in_amt = 3'd0; left_direction = 1'b0;
    in_mode = 2'b00; out_ready = 1'b0; rst_n = 1'b0;
    test_reset();
    test_left_logical();
    test_right_arith();
    test_rotate();
    test_mode_reserved();
    test_amt_zero();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_shift_engine
